// File: rtl/lfsr_period_meter.sv
// lfsr_period_meter
// Measures the cycle length of an LFSR sequence by capturing a reference
// state on the first step after a start and counting steps until that
// state is seen again. If the reference has not recurred after 2**BITS
// steps, it is treated as a transient state and a timeout is reported.
module lfsr_period_meter #(
    parameter int BITS = 5
) (
    input  logic            clk,
    input  logic            reset_i,
    input  logic [BITS-1:0] state_i,
    input  logic            step_i,
    input  logic            start_i,
    output logic [BITS:0]   period_o,
    output logic            valid_o,
    output logic            timeout_o,
    output logic            busy_o,
    output logic            done_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } meter_state_t;

    // The step count that would give 2**BITS; reaching it without a match is a timeout
    localparam logic [BITS:0] FULL_COUNT = {1'b1, {BITS{1'b0}}};

    meter_state_t    r_state;
    meter_state_t    w_stateNext;

    logic [BITS-1:0] r_ref;
    logic [BITS-1:0] w_refNext;
    logic [BITS-1:0] r_count;
    logic [BITS-1:0] w_countNext;
    logic [BITS:0]   r_period;
    logic [BITS:0]   w_periodNext;
    logic            r_valid;
    logic            w_validNext;
    logic            r_timeout;
    logic            w_timeoutNext;
    logic            r_done;
    logic            w_doneNext;
    logic            r_busy;
    logic            w_busyNext;

    logic [BITS:0]   w_n;
    logic            w_match;
    logic            w_full;

    // The match test uses the step count including the current step
    assign w_n     = {1'b0, r_count} + (BITS+1)'(1);
    assign w_match = (state_i == r_ref);
    assign w_full  = (w_n == FULL_COUNT);

    // State register; reset returns the meter to IDLE
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic: start always (re)arms, completion returns to IDLE
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_stateNext = ARM;
                end
            end
            ARM: begin
                if (start_i) begin
                    w_stateNext = ARM;
                end else if (step_i) begin
                    w_stateNext = MEASURE;
                end
            end
            MEASURE: begin
                if (start_i) begin
                    w_stateNext = ARM;
                end else if (step_i && (w_match || w_full)) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Output/datapath next values; match is tested before timeout so a full-length period is reported
    always_comb begin
        w_refNext     = r_ref;
        w_countNext   = r_count;
        w_periodNext  = r_period;
        w_validNext   = r_valid;
        w_timeoutNext = r_timeout;
        w_doneNext    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_countNext   = '0;
                    w_periodNext  = '0;
                    w_validNext   = 1'b0;
                    w_timeoutNext = 1'b0;
                end
            end
            ARM: begin
                if (start_i) begin
                    w_countNext   = '0;
                    w_periodNext  = '0;
                    w_validNext   = 1'b0;
                    w_timeoutNext = 1'b0;
                end else if (step_i) begin
                    w_refNext   = state_i;
                    w_countNext = '0;
                end
            end
            MEASURE: begin
                if (start_i) begin
                    w_countNext   = '0;
                    w_periodNext  = '0;
                    w_validNext   = 1'b0;
                    w_timeoutNext = 1'b0;
                end else if (step_i) begin
                    if (w_match) begin
                        w_periodNext  = w_n;
                        w_validNext   = 1'b1;
                        w_timeoutNext = 1'b0;
                        w_doneNext    = 1'b1;
                    end else if (w_full) begin
                        w_periodNext  = '0;
                        w_validNext   = 1'b0;
                        w_timeoutNext = 1'b1;
                        w_doneNext    = 1'b1;
                    end else begin
                        w_countNext = w_n[BITS-1:0];
                    end
                end
            end
            default: begin
                w_countNext = '0;
            end
        endcase
        w_busyNext = (w_stateNext != IDLE);
    end

    // Datapath and output registers so every output comes straight from a flop
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_ref     <= '0;
            r_count   <= '0;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_ref     <= w_refNext;
            r_count   <= w_countNext;
            r_period  <= w_periodNext;
            r_valid   <= w_validNext;
            r_timeout <= w_timeoutNext;
            r_done    <= w_doneNext;
            r_busy    <= w_busyNext;
        end
    end

    assign period_o  = r_period;
    assign valid_o   = r_valid;
    assign timeout_o = r_timeout;
    assign busy_o    = r_busy;
    assign done_o    = r_done;

endmodule

// File: tb/tb_lfsr_period_meter.sv
// tb_lfsr_period_meter
// Drives lfsr_period_meter from a behavioural LFSR and predicts results from
// the list of stepped states seen since the last start.
module tb_lfsr_period_meter;

    localparam int BITS = 5;
    localparam int FULL = 1 << BITS;

    typedef struct packed {
        logic [BITS:0] period;
        logic          valid;
        logic          timeout;
    } result_t;

    logic            clk = 1'b0;
    logic            reset_i = 1'b1;
    logic [BITS-1:0] state_i = '0;
    logic            step_i = 1'b0;
    logic            start_i = 1'b0;
    logic [BITS:0]   period_o;
    logic            valid_o;
    logic            timeout_o;
    logic            busy_o;
    logic            done_o;

    int totalChecks = 0;
    int badChecks = 0;
    bit simOver = 1'b0;

    logic [BITS-1:0] lfsrState = '0;
    logic [BITS-1:0] taps = 5'b10100;

    bit              active = 1'b0;
    bit              expBusy = 1'b0;
    bit              expDone = 1'b0;
    int              expPeriod = 0;
    bit              expValid = 1'b0;
    bit              expTimeout = 1'b0;
    logic [BITS-1:0] stepQ[$];
    result_t         scoreQ[$];

    lfsr_period_meter #(.BITS(BITS)) dut (
        .clk       (clk),
        .reset_i   (reset_i),
        .state_i   (state_i),
        .step_i    (step_i),
        .start_i   (start_i),
        .period_o  (period_o),
        .valid_o   (valid_o),
        .timeout_o (timeout_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [BITS-1:0] lfsrNext(input logic [BITS-1:0] s, input logic [BITS-1:0] t);
        return {s[BITS-2:0], ^(s & t)};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        totalChecks++;
        if (actual != expected) begin
            badChecks++;
            $display("[TB] FAIL %s actual=%0d expected=%0d time=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic finishMeasurement(input int period, input bit valid, input bit timeout);
        result_t r;
        r.period   = (BITS+1)'(period);
        r.valid    = valid;
        r.timeout  = timeout;
        expPeriod  = period;
        expValid   = valid;
        expTimeout = timeout;
        expDone    = 1'b1;
        active     = 1'b0;
        scoreQ.push_back(r);
    endtask

    // One clock of stimulus, with the reference model updated for its effect
    task automatic applyStimulus(input bit doStart, input bit doStep, input bit doReset);
        int n;
        @(negedge clk);
        if (doStep) begin
            lfsrState = lfsrNext(lfsrState, taps);
        end
        state_i = lfsrState;
        step_i  = doStep;
        start_i = doStart;
        reset_i = doReset;
        expDone = 1'b0;
        if (doReset) begin
            active     = 1'b0;
            expPeriod  = 0;
            expValid   = 1'b0;
            expTimeout = 1'b0;
            stepQ.delete();
            scoreQ.delete();
        end else if (doStart) begin
            active     = 1'b1;
            expPeriod  = 0;
            expValid   = 1'b0;
            expTimeout = 1'b0;
            stepQ.delete();
        end else if (doStep && active) begin
            stepQ.push_back(lfsrState);
            n = stepQ.size() - 1;
            if (n >= 1 && stepQ[n] == stepQ[0]) begin
                finishMeasurement(n, 1'b1, 1'b0);
            end else if (n == FULL) begin
                finishMeasurement(0, 1'b0, 1'b1);
            end
        end
        expBusy = active;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic runSteps(input int maxSteps, input int gap, input bit stopWhenDone);
        for (int i = 0; i < maxSteps; i++) begin
            if (stopWhenDone && !active) break;
            applyStimulus(1'b0, 1'b1, 1'b0);
            idle(gap);
        end
    endtask

    task automatic checkDrained(input string name);
        idle(2);
        checkOutput(name, scoreQ.size(), 0);
    endtask

    // Monitor: per-cycle output check plus scoreboard pop on each done pulse
    always @(posedge clk) begin
        result_t r;
        #1;
        if (!simOver) begin
            checkOutput("busy", int'(busy_o), int'(expBusy));
            checkOutput("done", int'(done_o), int'(expDone));
            checkOutput("period", int'(period_o), expPeriod);
            checkOutput("valid", int'(valid_o), int'(expValid));
            checkOutput("timeout", int'(timeout_o), int'(expTimeout));
            if (done_o) begin
                checkOutput("score_available", int'(scoreQ.size() > 0), 1);
                if (scoreQ.size() > 0) begin
                    r = scoreQ.pop_front();
                    checkOutput("score_period", int'(period_o), int'(r.period));
                    checkOutput("score_valid", int'(valid_o), int'(r.valid));
                    checkOutput("score_timeout", int'(timeout_o), int'(r.timeout));
                end
            end
        end
    end

    // Hard stop in case the stimulus thread ever stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios followed by randomized measurements
    initial begin
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        idle(2);

        // Maximal taps from seed 1, stepping every 4 cycles; idle steps afterwards are ignored
        taps = 5'b10100;
        lfsrState = 5'h01;
        applyStimulus(1'b1, 1'b0, 1'b0);
        runSteps(40, 3, 1'b1);
        runSteps(3, 0, 1'b0);
        checkDrained("drain_maximal");

        // All-zero lock state recurs after a single step
        lfsrState = 5'h00;
        applyStimulus(1'b1, 1'b0, 1'b0);
        runSteps(5, 0, 1'b1);
        checkDrained("drain_zero");

        // Non-invertible taps: reference is a transient state and never recurs
        taps = 5'b00001;
        lfsrState = 5'b10110;
        applyStimulus(1'b1, 1'b0, 1'b0);
        runSteps(40, 0, 1'b1);
        checkDrained("drain_transient");

        // Restart mid-measurement, then restart coinciding with a step
        taps = 5'b10100;
        lfsrState = 5'h01;
        applyStimulus(1'b1, 1'b0, 1'b0);
        runSteps(10, 1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        runSteps(5, 0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        runSteps(40, 1, 1'b1);
        checkDrained("drain_restart");

        // Reset together with step and start in the middle of a measurement
        applyStimulus(1'b1, 1'b0, 1'b0);
        runSteps(6, 0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        idle(3);

        // Start with a coincident step in IDLE, then a long pause before steps resume
        applyStimulus(1'b1, 1'b1, 1'b0);
        idle(20);
        runSteps(40, 0, 1'b1);
        checkDrained("drain_gated");

        // Randomized taps, seeds, step spacing and occasional restarts
        for (int m = 0; m < 10; m++) begin
            taps = BITS'($urandom_range(1, FULL - 1));
            lfsrState = BITS'($urandom_range(0, FULL - 1));
            applyStimulus(1'b1, 1'b0, 1'b0);
            for (int s = 0; s < 90 && active; s++) begin
                if ($urandom_range(0, 39) == 0) begin
                    applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0);
                end else begin
                    applyStimulus(1'b0, 1'b1, 1'b0);
                end
                idle(int'($urandom_range(0, 2)));
            end
            runSteps(40, 0, 1'b1);
            checkDrained("drain_random");
        end

        idle(1);
        @(posedge clk);
        #2;
        simOver = 1'b1;
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
